// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, FSM state encoding and reset coefficients for the multi-channel FIR engine.
package fir_pkg;

    localparam int CH    = 4;
    localparam int TAPS  = 4;
    localparam int DW    = 8;
    localparam int CW    = 8;
    localparam int ACCW  = 18;
    localparam int SHIFT = 8;
    localparam int CHW   = (CH > 1) ? $clog2(CH) : 1;
    localparam int TW    = (TAPS > 1) ? $clog2(TAPS) : 1;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    function automatic logic [CW-1:0] default_coeff(input int k);
        return (k == 0) ? CW'(17) :
               (k == 1) ? CW'(13) :
               (k == 2) ? CW'(47) :
               (k == 3) ? CW'(48) : '0;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, searching upward from ptr and wrapping.
module rr_arbiter
    import fir_pkg::*;
(
    input  logic [CH-1:0]  req,
    input  logic [CHW-1:0] ptr,
    output logic [CH-1:0]  grant,
    output logic [CHW-1:0] idx
);

    logic [CHW-1:0] c;

    // Scan from farthest to nearest so the closest requester to ptr wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        c     = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            c = CHW'((int'(ptr) + i) % CH);
            if (req[c]) begin
                grant    = '0;
                grant[c] = 1'b1;
                idx      = c;
            end
        end
    end

endmodule

// File: rtl/fir_mc_scheduler.sv
// fir_mc_scheduler: CH sample streams share one MAC datapath; per-channel delay lines,
// shared coefficient table writable only while idle.
module fir_mc_scheduler
    import fir_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [CH-1:0]      s_valid,
    input  logic [CH*DW-1:0]   s_data,
    output logic [CH-1:0]      s_ready,
    output logic               m_valid,
    output logic [DW-1:0]      m_data,
    output logic [CHW-1:0]     m_chan,
    input  logic               m_ready,
    input  logic               cfg_we,
    input  logic [TW-1:0]      cfg_addr,
    input  logic [CW-1:0]      cfg_data,
    output logic               cfg_ready
);

    state_t                 state, state_d;
    logic [DW-1:0]          hist [CH][TAPS];
    logic [CW-1:0]          coeff [TAPS];
    logic [CH-1:0][DW-1:0]  lanes;
    logic [ACCW-1:0]        acc, acc_d, shifted;
    logic [DW+CW-1:0]       prod;
    logic [TW-1:0]          tap;
    logic [CHW-1:0]         chan, rr, gidx;
    logic [CH-1:0]          grant;
    logic                   take, last;

    rr_arbiter u_arb (
        .req   (s_valid),
        .ptr   (rr),
        .grant (grant),
        .idx   (gidx)
    );

    assign lanes     = s_data;
    assign s_ready   = (state == IDLE && rst) ? grant : '0;
    assign take      = |s_ready;
    assign cfg_ready = state == IDLE;
    assign m_valid   = state == OUT;
    assign m_chan    = chan;
    assign prod      = hist[chan][tap] * coeff[tap];
    assign acc_d     = acc + ACCW'(prod);
    assign shifted   = acc_d >> SHIFT;
    assign last      = tap == TW'(TAPS - 1);

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (take) state_d = MAC;
            MAC:     if (last) state_d = OUT;
            OUT:     if (m_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CH; i++)
                for (int k = 0; k < TAPS; k++)
                    hist[i][k] <= '0;
            for (int k = 0; k < TAPS; k++)
                coeff[k] <= default_coeff(k);
            acc    <= '0;
            tap    <= '0;
            chan   <= '0;
            rr     <= '0;
            m_data <= '0;
        end else begin
            // A same-cycle write lands before the MAC starts, so the new sample sees it.
            if (cfg_ready && cfg_we)
                coeff[cfg_addr] <= cfg_data;
            if (take) begin
                hist[gidx][0] <= lanes[gidx];
                for (int k = 1; k < TAPS; k++)
                    hist[gidx][k] <= hist[gidx][k-1];
                acc  <= '0;
                tap  <= '0;
                chan <= gidx;
            end
            if (state == MAC) begin
                acc <= acc_d;
                tap <= tap + 1'b1;
                if (last)
                    m_data <= (|shifted[ACCW-1:DW]) ? '1 : shifted[DW-1:0];
            end
            if (state == OUT && m_ready)
                rr <= (chan == CHW'(CH - 1)) ? '0 : chan + 1'b1;
        end
    end

endmodule

// File: tb/tb_fir_mc_scheduler.sv
// tb_fir_mc_scheduler: directed vector table plus randomized traffic checked against a
// transaction-level reference model of the FIR scheduler.
module tb_fir_mc_scheduler;
    import fir_pkg::*;

    logic               clk = 0;
    logic               rst = 0;
    logic [CH-1:0]      s_valid = '0;
    logic [CH*DW-1:0]   s_data = '0;
    logic [CH-1:0]      s_ready;
    logic               m_valid;
    logic [DW-1:0]      m_data;
    logic [CHW-1:0]     m_chan;
    logic               m_ready = 0;
    logic               cfg_we = 0;
    logic [TW-1:0]      cfg_addr = '0;
    logic [CW-1:0]      cfg_data = '0;
    logic               cfg_ready;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    fir_mc_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_chan    (m_chan),
        .m_ready   (m_ready),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: one engine, busy for TAPS cycles per sample, then holds its result.
    int mh [CH][TAPS];
    int mc [TAPS];
    int m_rr, m_cnt, m_g, m_exp;
    bit m_idle, m_out;

    function automatic int pick(input logic [CH-1:0] v, input int p);
        for (int i = 0; i < CH; i++)
            if (v[(p + i) % CH]) return (p + i) % CH;
        return -1;
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < CH; i++)
            for (int k = 0; k < TAPS; k++)
                mh[i][k] = 0;
        mc[0] = 17; mc[1] = 13; mc[2] = 47; mc[3] = 48;
        m_rr = 0; m_cnt = 0; m_g = 0; m_exp = 0;
        m_idle = 1; m_out = 0;
    endtask

    always @(negedge clk) begin
        int g;
        int sum;
        logic [CH-1:0] er;
        if (!rst) begin
            mdl_reset();
        end else begin
            g = m_idle ? pick(s_valid, m_rr) : -1;
            er = '0;
            if (g >= 0) er[g] = 1'b1;
            chk("s_ready", 32'(s_ready), 32'(er));
            chk("cfg_ready", 32'(cfg_ready), 32'(m_idle));
            chk("m_valid", 32'(m_valid), 32'(m_out));
            if (m_out) begin
                chk("m_data", 32'(m_data), m_exp);
                chk("m_chan", 32'(m_chan), m_g);
            end
            if (m_idle) begin
                if (cfg_we) mc[cfg_addr] = int'(cfg_data);
                if (g >= 0) begin
                    for (int k = TAPS - 1; k > 0; k--) mh[g][k] = mh[g][k-1];
                    mh[g][0] = int'(s_data[g*DW +: DW]);
                    sum = 0;
                    for (int k = 0; k < TAPS; k++) sum += mh[g][k] * mc[k];
                    m_exp = ((sum >> SHIFT) > (1 << DW) - 1) ? (1 << DW) - 1 : (sum >> SHIFT);
                    m_g = g;
                    m_cnt = TAPS;
                    m_idle = 0;
                end
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) m_out = 1;
            end else if (m_out && m_ready) begin
                m_out = 0;
                m_idle = 1;
                m_rr = (m_g + 1) % CH;
            end
        end
    end

    typedef struct {
        int ch;
        int smp;
        int exp;
        int pre;
    } vec_t;

    vec_t tbl [7];

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        rst = 1;
    endtask

    task automatic cfg_all(input int v);
        for (int a = 0; a < TAPS; a++) begin
            @(posedge clk); #1;
            cfg_we = 1; cfg_addr = TW'(a); cfg_data = CW'(v);
        end
        @(posedge clk); #1;
        cfg_we = 0;
    endtask

    task automatic send(input int ch, input int smp, input int exp, input bit mac_cfg);
        int t0;
        bit ok;
        t0 = 0;
        @(posedge clk); #1;
        s_valid = '0;
        s_valid[ch] = 1'b1;
        s_data[ch*DW +: DW] = DW'(smp);
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (s_ready[ch]) begin ok = 1; t0 = cyc; end
        end
        chk("hs_seen", 32'(ok), 1);
        @(posedge clk); #1;
        s_valid = '0;
        if (mac_cfg) begin
            cfg_we = 1; cfg_addr = '0; cfg_data = 8'd200;
            @(posedge clk); #1;
            cfg_we = 0;
        end
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (m_valid) ok = 1;
        end
        chk("out_seen", 32'(ok), 1);
        chk("latency", cyc - t0, TAPS + 1);
        chk("vec_data", 32'(m_data), exp);
        chk("vec_chan", 32'(m_chan), ch);
        @(posedge clk); #1;
        m_ready = 1;
        @(posedge clk); #1;
        m_ready = 0;
    endtask

    initial begin
        int n;
        bit ok;
        logic [DW-1:0] d;
        logic [CHW-1:0] c;

        tbl[0] = '{0, 100, 6, -1};
        tbl[1] = '{0, 100, 11, -1};
        tbl[2] = '{1, 0, 0, -1};
        tbl[3] = '{2, 255, 254, 255};
        tbl[4] = '{2, 255, 255, -1};
        tbl[5] = '{2, 255, 255, -1};
        tbl[6] = '{2, 255, 255, -1};

        s_valid = '1;
        @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_m_chan", 32'(m_chan), 0);
        @(posedge clk); #1;
        s_valid = '0;
        rst = 1;

        for (int i = 0; i < 7; i++) begin
            if (tbl[i].pre >= 0) cfg_all(tbl[i].pre);
            send(tbl[i].ch, tbl[i].smp, tbl[i].exp, 0);
        end

        // Fairness with every channel requesting.
        do_reset();
        @(posedge clk); #1;
        s_valid = '1;
        s_data = (CH*DW)'($urandom);
        m_ready = 1;
        n = 0;
        for (int i = 0; i < 100 && n < 5; i++) begin
            @(negedge clk);
            if (s_ready != 0) begin
                chk("grant_order", 32'(s_ready), 32'(1) << (n % CH));
                n++;
            end
        end
        chk("grants_seen", n, 5);
        @(posedge clk); #1;
        s_valid = '0;
        repeat (10) @(posedge clk);
        #1;

        // Back-pressure: output must hold while m_ready is low.
        m_ready = 0;
        s_valid = 4'b0011;
        s_data = (CH*DW)'($urandom);
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (m_valid) ok = 1;
        end
        chk("stall_out_seen", 32'(ok), 1);
        d = m_data;
        c = m_chan;
        repeat (10) begin
            @(negedge clk);
            chk("stall_valid", 32'(m_valid), 1);
            chk("stall_data", 32'(m_data), 32'(d));
            chk("stall_chan", 32'(m_chan), 32'(c));
            chk("stall_s_ready", 32'(s_ready), 0);
        end
        @(posedge clk); #1;
        m_ready = 1;
        s_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        m_ready = 0;

        // Coefficient write during MAC must be dropped.
        do_reset();
        send(0, 100, 6, 1);
        send(0, 100, 11, 0);

        // Reset mid-MAC discards the result and clears histories.
        @(posedge clk); #1;
        s_valid = 4'b0001;
        s_data[DW-1:0] = 8'd100;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (s_ready[0]) ok = 1;
        end
        chk("mac_rst_hs", 32'(ok), 1);
        @(posedge clk); #1;
        s_valid = '0;
        @(posedge clk); #1;
        rst = 0;
        #1;
        chk("mac_rst_m_valid", 32'(m_valid), 0);
        @(posedge clk); #1;
        rst = 1;
        send(0, 100, 6, 0);

        // Reset while holding a result drops m_valid without waiting for a clock.
        @(posedge clk); #1;
        s_valid = 4'b1000;
        s_data[3*DW +: DW] = 8'd200;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (m_valid) ok = 1;
        end
        chk("out_rst_seen", 32'(ok), 1);
        @(posedge clk); #1;
        rst = 0;
        s_valid = '0;
        #1;
        chk("out_rst_m_valid", 32'(m_valid), 0);
        chk("out_rst_m_data", 32'(m_data), 0);
        @(posedge clk); #1;
        rst = 1;

        repeat (3000) begin
            @(posedge clk); #1;
            s_valid  = CH'($urandom);
            s_data   = (CH*DW)'($urandom);
            m_ready  = ($urandom % 4) != 0;
            cfg_we   = ($urandom % 8) == 0;
            cfg_addr = TW'($urandom);
            cfg_data = CW'($urandom);
        end
        @(posedge clk); #1;
        s_valid = '0;
        cfg_we = 0;
        m_ready = 1;
        repeat (12) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
